// File: rtl/heroe_decoder.sv
// heroe_decoder: debounced confirm, 7-seg pattern decode to (tipo, var),
// target compare and saturating hit score.
module heroe_decoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         seg_in,
    input  logic               btn_conf,
    input  logic               exp_valid,
    input  logic [2:0]         exp_tipo,
    input  logic [1:0]         exp_var,
    output logic [2:0]         tipo_d,
    output logic [1:0]         var_d,
    output logic               dec_valid,
    output logic               dec_err,
    output logic               hit,
    output logic               miss,
    output logic               armed,
    output logic [SCORE_W-1:0] score
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DEB    = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    // Counter starts at 0 on the first qualifying cycle, so the stage ends
    // on the edge where it would become DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic               btn_meta_q, btn_s_q;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         out_tipo_q, out_tipo_d;
    logic [1:0]         out_var_q, out_var_d;
    logic               out_err_q, out_err_d;
    logic               dec_valid_q, dec_valid_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               armed_q, armed_d;
    logic [2:0]         exp_tipo_q, exp_tipo_d;
    logic [1:0]         exp_var_q, exp_var_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic [2:0]         dec_tipo;
    logic [1:0]         dec_var;
    logic               dec_bad;
    logic               is_hit;

    // Two-flop synchroniser for the asynchronous confirm button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_conf;
            btn_s_q    <= btn_meta_q;
        end
    end

    // Pattern table: inverse of the hero pattern ROM
    always_comb begin
        dec_tipo = 3'd7;
        dec_var  = 2'd0;
        dec_bad  = 1'b0;
        case (seg_in)
            7'b0111110: begin dec_tipo = 3'd0; dec_var = 2'd0; end
            7'b0110000: begin dec_tipo = 3'd1; dec_var = 2'd0; end
            7'b1100111: begin dec_tipo = 3'd2; dec_var = 2'd0; end
            7'b1000111: begin dec_tipo = 3'd3; dec_var = 2'd0; end
            7'b1001111: begin dec_tipo = 3'd4; dec_var = 2'd0; end
            7'b0000001: begin dec_tipo = 3'd0; dec_var = 2'd1; end
            7'b1000000: begin dec_tipo = 3'd0; dec_var = 2'd2; end
            7'b0001000: begin dec_tipo = 3'd0; dec_var = 2'd3; end
            default:    dec_bad = 1'b1;
        endcase
    end

    // Figures must match exactly; actions only need the variant to match
    always_comb begin
        if (exp_var_q == 2'd0)
            is_hit = !dec_bad && dec_tipo == exp_tipo_q && dec_var == 2'd0;
        else
            is_hit = dec_var == exp_var_q;
    end

    // Debounce FSM, sampling and scoring
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_tipo_d  = out_tipo_q;
        out_var_d   = out_var_q;
        out_err_d   = out_err_q;
        dec_valid_d = 1'b0;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        armed_d     = armed_q;
        exp_tipo_d  = exp_tipo_q;
        exp_var_d   = exp_var_q;
        score_d     = score_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (btn_s_q) state_d = S_DEB;
            end
            S_DEB: begin
                if (!btn_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                out_tipo_d  = dec_tipo;
                out_var_d   = dec_var;
                out_err_d   = dec_bad;
                dec_valid_d = 1'b1;
                if (armed_q) begin
                    armed_d = 1'b0;
                    if (is_hit) begin
                        hit_d = 1'b1;
                        if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            default: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
        // A new target always wins, even in the judging cycle
        if (exp_valid) begin
            exp_tipo_d = exp_tipo;
            exp_var_d  = exp_var;
            armed_d    = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_tipo_q  <= 3'd0;
            out_var_q   <= 2'd0;
            out_err_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            armed_q     <= 1'b0;
            exp_tipo_q  <= 3'd0;
            exp_var_q   <= 2'd0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_tipo_q  <= out_tipo_d;
            out_var_q   <= out_var_d;
            out_err_q   <= out_err_d;
            dec_valid_q <= dec_valid_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            armed_q     <= armed_d;
            exp_tipo_q  <= exp_tipo_d;
            exp_var_q   <= exp_var_d;
            score_q     <= score_d;
        end
    end

    assign tipo_d    = out_tipo_q;
    assign var_d     = out_var_q;
    assign dec_err   = out_err_q;
    assign dec_valid = dec_valid_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign armed     = armed_q;
    assign score     = score_q;

endmodule
